// File: rtl/vga_scan.sv
// rtl/vga_scan.sv - VGA 800x525 timing generator with card-grid cell decode and registered blanked rgb.
// Optional build macro VGA_SCAN_GRID_LINES_EN draws white card outlines on cell offset 0.
module vga_scan #(
    parameter int CLK_DIV   = 2,
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int GRID_X0   = 128,
    parameter int GRID_Y0   = 48,
    parameter int CELL_SIZE = 64
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] rgb_in,
    output logic       pix_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       frame_start,
    output logic       cell_valid,
    output logic [2:0] cell_row,
    output logic [2:0] cell_col,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] rgb
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    localparam logic [9:0] GX0 = 10'(GRID_X0);
    localparam logic [9:0] GX1 = 10'(GRID_X0 + 6 * CELL_SIZE);
    localparam logic [9:0] GY0 = 10'(GRID_Y0);
    localparam logic [9:0] GY1 = 10'(GRID_Y0 + 6 * CELL_SIZE);
    localparam int CELL_SHIFT = $clog2(CELL_SIZE);

    logic [DIV_W-1:0] div;
    logic [9:0]       h_count;
    logic [9:0]       v_count;
    logic [9:0]       dx;
    logic [9:0]       dy;
    logic             hsync_raw;
    logic             vsync_raw;
    logic [2:0]       pix_color;

    assign pix_tick = (div == DIV_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            div <= '0;
        end else if (pix_tick) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (pix_tick) begin
            if (h_count == H_LAST) begin
                h_count <= '0;
                v_count <= (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
            end else begin
                h_count <= h_count + 10'd1;
            end
        end
    end

    assign pixel_x     = h_count;
    assign pixel_y     = v_count;
    assign video_on    = (h_count < H_VIS) && (v_count < V_VIS);
    assign frame_start = pix_tick && (h_count == 10'd0) && (v_count == 10'd0);
    assign hsync_raw   = !((h_count >= HS_START) && (h_count < HS_END));
    assign vsync_raw   = !((v_count >= VS_START) && (v_count < VS_END));

    // Offsets are only meaningful inside the grid; the cell outputs are masked otherwise.
    assign dx         = h_count - GX0;
    assign dy         = v_count - GY0;
    assign cell_valid = (h_count >= GX0) && (h_count < GX1) && (v_count >= GY0) && (v_count < GY1);
    assign cell_col   = cell_valid ? 3'(dx >> CELL_SHIFT) : 3'd0;
    assign cell_row   = cell_valid ? 3'(dy >> CELL_SHIFT) : 3'd0;

`ifdef VGA_SCAN_GRID_LINES_EN
    localparam logic [9:0] CELL_MASK = 10'(CELL_SIZE - 1);
    logic on_line;
    assign on_line   = ((dx & CELL_MASK) == 10'd0) || ((dy & CELL_MASK) == 10'd0);
    assign pix_color = (cell_valid && on_line) ? 3'b111 : rgb_in;
`else
    assign pix_color = rgb_in;
`endif

    // Colour and sync share one register stage so they stay aligned at the pins.
    always_ff @(posedge clock) begin
        if (reset) begin
            rgb   <= 3'd0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (pix_tick) begin
            rgb   <= video_on ? pix_color : 3'd0;
            hsync <= hsync_raw;
            vsync <= vsync_raw;
        end
    end

endmodule

// File: tb/tb_vga_scan.sv
// tb/tb_vga_scan.sv - randomized self-checking bench for vga_scan, default and reduced timing instances.
`timescale 1ns/1ps
module tb_vga_scan;

    typedef struct {
        int d, ha, hf, hs, hb, va, vf, vs, vb, gx, gy, cs;
    } cfg_t;

    localparam int S_DIV = 3;
    localparam int S_HA = 40, S_HF = 4, S_HS = 6, S_HB = 6;
    localparam int S_VA = 30, S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_GX = 8, S_GY = 3, S_CS = 4;

    logic       clk = 1'b0;
    logic [1:0] rst;
    logic [2:0] rgb_in;
    logic [1:0] pix_tick, video_on, frame_start, cell_valid, hsync, vsync;
    logic [9:0] px [2];
    logic [9:0] py [2];
    logic [2:0] crow [2];
    logic [2:0] ccol [2];
    logic [2:0] rgb [2];

    always #5 clk = ~clk;

    vga_scan u_full (
        .clock(clk), .reset(rst[0]), .rgb_in(rgb_in),
        .pix_tick(pix_tick[0]), .pixel_x(px[0]), .pixel_y(py[0]),
        .video_on(video_on[0]), .frame_start(frame_start[0]),
        .cell_valid(cell_valid[0]), .cell_row(crow[0]), .cell_col(ccol[0]),
        .hsync(hsync[0]), .vsync(vsync[0]), .rgb(rgb[0])
    );

    vga_scan #(
        .CLK_DIV(S_DIV), .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .GRID_X0(S_GX), .GRID_Y0(S_GY), .CELL_SIZE(S_CS)
    ) u_small (
        .clock(clk), .reset(rst[1]), .rgb_in(rgb_in),
        .pix_tick(pix_tick[1]), .pixel_x(px[1]), .pixel_y(py[1]),
        .video_on(video_on[1]), .frame_start(frame_start[1]),
        .cell_valid(cell_valid[1]), .cell_row(crow[1]), .cell_col(ccol[1]),
        .hsync(hsync[1]), .vsync(vsync[1]), .rgb(rgb[1])
    );

    int   checks = 0;
    int   failures = 0;
    cfg_t cfg [2];
    int   c [2];
    int   last_fs [2];
    int   fl_cnt [2];
    logic [2:0] e_rgb [2];
    logic e_hs [2];
    logic e_vs [2];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Beam position after cc system clocks of free running from reset release.
    task automatic where(input int i, input int cc, output int n, output int h, output int v,
                         output bit tick);
        int ht, vt;
        ht   = cfg[i].ha + cfg[i].hf + cfg[i].hs + cfg[i].hb;
        vt   = cfg[i].va + cfg[i].vf + cfg[i].vs + cfg[i].vb;
        n    = cc / cfg[i].d;
        tick = (cc % cfg[i].d) == cfg[i].d - 1;
        h    = n % ht;
        v    = (n / ht) % vt;
    endtask

    task automatic check_inst(input int i);
        int n, h, v, ht, vt, ecol, erow;
        bit tick, vis, cv;
        where(i, c[i], n, h, v, tick);
        ht   = cfg[i].ha + cfg[i].hf + cfg[i].hs + cfg[i].hb;
        vt   = cfg[i].va + cfg[i].vf + cfg[i].vs + cfg[i].vb;
        vis  = (h < cfg[i].ha) && (v < cfg[i].va);
        cv   = (h >= cfg[i].gx) && (h < cfg[i].gx + 6 * cfg[i].cs) &&
               (v >= cfg[i].gy) && (v < cfg[i].gy + 6 * cfg[i].cs);
        ecol = cv ? (h - cfg[i].gx) / cfg[i].cs : 0;
        erow = cv ? (v - cfg[i].gy) / cfg[i].cs : 0;
        chk($sformatf("pix_tick%0d", i), 16'(pix_tick[i]), 16'(tick));
        chk($sformatf("pixel_x%0d", i), 16'(px[i]), 16'(h));
        chk($sformatf("pixel_y%0d", i), 16'(py[i]), 16'(v));
        chk($sformatf("video_on%0d", i), 16'(video_on[i]), 16'(vis));
        chk($sformatf("frame_start%0d", i), 16'(frame_start[i]), 16'(tick && h == 0 && v == 0));
        chk($sformatf("cell_valid%0d", i), 16'(cell_valid[i]), 16'(cv));
        chk($sformatf("cell_col%0d", i), 16'(ccol[i]), 16'(ecol));
        chk($sformatf("cell_row%0d", i), 16'(crow[i]), 16'(erow));
        chk($sformatf("hsync%0d", i), 16'(hsync[i]), 16'(e_hs[i]));
        chk($sformatf("vsync%0d", i), 16'(vsync[i]), 16'(e_vs[i]));
        chk($sformatf("rgb%0d", i), 16'(rgb[i]), 16'(e_rgb[i]));
        if (tick && frame_start[i] === 1'b1) begin
            if (last_fs[i] >= 0) begin
                chk($sformatf("frame_len%0d", i), 16'(n - last_fs[i]), 16'(ht * vt));
                fl_cnt[i]++;
            end
            last_fs[i] = n;
        end
    endtask

    task automatic update_inst(input int i);
        int n, h, v;
        bit tick, vis, cv;
        logic [2:0] colour;
        if (rst[i]) begin
            c[i]       = 0;
            e_rgb[i]   = 3'd0;
            e_hs[i]    = 1'b1;
            e_vs[i]    = 1'b1;
            last_fs[i] = -1;
        end else begin
            where(i, c[i], n, h, v, tick);
            if (tick) begin
                vis = (h < cfg[i].ha) && (v < cfg[i].va);
                cv  = (h >= cfg[i].gx) && (h < cfg[i].gx + 6 * cfg[i].cs) &&
                      (v >= cfg[i].gy) && (v < cfg[i].gy + 6 * cfg[i].cs);
                colour = rgb_in;
`ifdef VGA_SCAN_GRID_LINES_EN
                if (cv && (((h - cfg[i].gx) % cfg[i].cs == 0) || ((v - cfg[i].gy) % cfg[i].cs == 0)))
                    colour = 3'b111;
`endif
                e_rgb[i] = vis ? colour : 3'd0;
                e_hs[i]  = !((h >= cfg[i].ha + cfg[i].hf) && (h < cfg[i].ha + cfg[i].hf + cfg[i].hs));
                e_vs[i]  = !((v >= cfg[i].va + cfg[i].vf) && (v < cfg[i].va + cfg[i].vf + cfg[i].vs));
            end
            c[i]++;
        end
    endtask

    // Check at the falling edge, then drive the inputs for the next rising edge.
    task automatic step(input logic [1:0] nrst, input logic [2:0] nrgb);
        check_inst(0);
        check_inst(1);
        rst    = nrst;
        rgb_in = nrgb;
        update_inst(0);
        update_inst(1);
        @(negedge clk);
    endtask

    initial begin
        int  n, h, v;
        bit  tick;
        bit  done0, done1;
        logic [1:0] r;
        cfg[0] = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 128, 48, 64};
        cfg[1] = '{S_DIV, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, S_GX, S_GY, S_CS};
        for (int i = 0; i < 2; i++) begin
            c[i] = 0; e_rgb[i] = 3'd0; e_hs[i] = 1'b1; e_vs[i] = 1'b1;
            last_fs[i] = -1; fl_cnt[i] = 0;
        end
        rst    = 2'b11;
        rgb_in = 3'd0;
        @(negedge clk);

        repeat (5) step(2'b11, 3'd0);
        repeat (13000) step(2'b00, 3'($urandom));

        // Mid-line/mid-frame reset of each instance at a chosen beam position.
        done0 = 1'b0;
        done1 = 1'b0;
        for (int t = 0; t < 20000 && !(done0 && done1); t++) begin
            r = 2'b00;
            where(0, c[0], n, h, v, tick);
            if (!done0 && tick && h == 300) begin r[0] = 1'b1; done0 = 1'b1; end
            where(1, c[1], n, h, v, tick);
            if (!done1 && tick && h == 20 && v == 15) begin r[1] = 1'b1; done1 = 1'b1; end
            step(r, 3'($urandom));
        end
        checks++;
        assert (done0 && done1) else begin
            failures++;
            $error("FAIL mid_reset_reached observed=%0d%0d expected=11", done0, done1);
        end

        repeat (14000) step(2'b00, 3'b101);
        check_inst(0);
        check_inst(1);

        checks++;
        assert (fl_cnt[1] >= 4) else begin
            failures++;
            $error("FAIL frame_intervals observed=%0d expected>=4", fl_cnt[1]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
